// File: rtl/arith_ctrl_pkg.sv
// Shared encodings and sizing for the AU micro-operation sequencer.
package arith_ctrl_pkg;

    localparam int unsigned WORD_W    = 30;
    localparam int unsigned MUL_STEPS = 30;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_MUL = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_LOAD      = 4'd1,
        ST_WAIT_OP   = 4'd2,
        ST_MOVE_B    = 4'd3,
        ST_NEGATE    = 4'd4,
        ST_SUM       = 4'd5,
        ST_STORE     = 4'd6,
        ST_AND_OP    = 4'd7,
        ST_MUL_ADD   = 4'd8,
        ST_MUL_SHIFT = 4'd9
    } state_e;

endpackage

// File: rtl/arith_ctrl.sv
// Sequencer issuing AU strobes for ADD/SUB/AND and shift-add fractional MUL.
// Operand 1 is in C at start; operand 2 arrives in C via req/ack; result ends in C.
module arith_ctrl #(
    parameter int unsigned WORD_W    = arith_ctrl_pkg::WORD_W,
    parameter int unsigned MUL_STEPS = arith_ctrl_pkg::MUL_STEPS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_from_op,
    input  logic [1:0] op_sel_from_op,
    output logic       busy_to_op,
    output logic       opnd_req_to_op,
    input  logic       opnd_ack_from_op,
    output logic       done_to_op,
    output logic       carry_to_op,
    input  logic       carry_out_from_au,
    input  logic       reg_b0_from_au,
    input  logic       reg_c1_from_au,
    input  logic       reg_c30_from_au,
    output logic       do_clear_b_to_au,
    output logic       do_not_b_to_au,
    output logic       do_sum_to_au,
    output logic       do_and_to_au,
    output logic       do_right_shift_bc_to_au,
    output logic       do_move_c_to_a_to_au,
    output logic       do_move_c_to_b_to_au,
    output logic       do_move_b_to_c_to_au
);

    import arith_ctrl_pkg::*;

    localparam int unsigned CNT_W = $clog2(WORD_W + 1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic             carry_q, carry_d;

    // These AU status bits are part of the AU bus but not needed by this sequencer.
    logic unused_au_status;
    assign unused_au_status = carry_out_from_au ^ reg_c1_from_au;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        step_d  = step_q;
        carry_d = carry_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_from_op) begin
                    state_d = ST_LOAD;
                    op_d    = op_e'(op_sel_from_op);
                end
            end
            ST_LOAD: state_d = ST_WAIT_OP;
            ST_WAIT_OP: begin
                if (opnd_ack_from_op) begin
                    step_d = '0;
                    unique case (op_q)
                        OP_ADD, OP_SUB: state_d = ST_MOVE_B;
                        OP_AND:         state_d = ST_AND_OP;
                        default:        state_d = ST_MUL_ADD;
                    endcase
                end
            end
            ST_MOVE_B:  state_d = (op_q == OP_SUB) ? ST_NEGATE : ST_SUM;
            ST_NEGATE:  state_d = ST_SUM;
            ST_SUM:     state_d = ST_STORE;
            ST_STORE: begin
                carry_d = reg_b0_from_au;
                state_d = ST_IDLE;
            end
            ST_AND_OP: begin
                carry_d = 1'b0;
                state_d = ST_IDLE;
            end
            ST_MUL_ADD: state_d = ST_MUL_SHIFT;
            ST_MUL_SHIFT: begin
                // Counter leaves for STORE on reaching MUL_STEPS, so it never wraps.
                step_d  = step_q + CNT_W'(1);
                state_d = (step_d == CNT_W'(MUL_STEPS)) ? ST_STORE : ST_MUL_ADD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            step_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            step_q  <= step_d;
            carry_q <= carry_d;
        end
    end

    // Strobes decode the registered state; only the MUL add is gated by the multiplier LSB.
    always_comb begin
        do_clear_b_to_au        = 1'b0;
        do_not_b_to_au          = 1'b0;
        do_sum_to_au            = 1'b0;
        do_and_to_au            = 1'b0;
        do_right_shift_bc_to_au = 1'b0;
        do_move_c_to_a_to_au    = 1'b0;
        do_move_c_to_b_to_au    = 1'b0;
        do_move_b_to_c_to_au    = 1'b0;
        opnd_req_to_op          = 1'b0;
        done_to_op              = 1'b0;
        unique case (state_q)
            ST_LOAD: begin
                do_move_c_to_a_to_au = 1'b1;
                do_clear_b_to_au     = 1'b1;
            end
            ST_WAIT_OP:   opnd_req_to_op          = 1'b1;
            ST_MOVE_B:    do_move_c_to_b_to_au    = 1'b1;
            ST_NEGATE:    do_not_b_to_au          = 1'b1;
            ST_SUM:       do_sum_to_au            = 1'b1;
            ST_STORE: begin
                do_move_b_to_c_to_au = 1'b1;
                done_to_op           = 1'b1;
            end
            ST_AND_OP: begin
                do_and_to_au = 1'b1;
                done_to_op   = 1'b1;
            end
            ST_MUL_ADD:   do_sum_to_au            = reg_c30_from_au;
            ST_MUL_SHIFT: do_right_shift_bc_to_au = 1'b1;
            default: ;
        endcase
    end

    assign busy_to_op  = (state_q != ST_IDLE);
    assign carry_to_op = carry_q;

endmodule

// File: tb/tb_arith_ctrl.sv
// Bench for arith_ctrl: behavioural AU plus memory stub, fixed vectors,
// multi-cycle corner sequences and random ops against an arithmetic reference.
module tb_arith_ctrl;

    localparam int unsigned    W     = 30;
    localparam int unsigned    STEPS = 30;
    localparam longint unsigned MOD  = 64'd1 << W;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_from_op;
    logic [1:0]   op_sel_from_op;
    logic         opnd_ack_from_op;
    logic         busy_to_op, opnd_req_to_op, done_to_op, carry_to_op;
    logic         carry_out_from_au, reg_b0_from_au, reg_c1_from_au, reg_c30_from_au;
    logic         do_clear_b_to_au, do_not_b_to_au, do_sum_to_au, do_and_to_au;
    logic         do_right_shift_bc_to_au, do_move_c_to_a_to_au;
    logic         do_move_c_to_b_to_au, do_move_b_to_c_to_au;

    logic         tb_load_c, mem_wr;
    logic [W-1:0] tb_load_val, opnd_val;

    logic [W-1:0] au_a = '0;
    logic [W:0]   au_b = '0;
    logic [W-1:0] au_c = '0;
    logic         au_cin = 1'b0;
    logic [W:0]   au_sum;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic [11:0] all_outs;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    arith_ctrl #(.WORD_W(W), .MUL_STEPS(STEPS)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .start_from_op          (start_from_op),
        .op_sel_from_op         (op_sel_from_op),
        .busy_to_op             (busy_to_op),
        .opnd_req_to_op         (opnd_req_to_op),
        .opnd_ack_from_op       (opnd_ack_from_op),
        .done_to_op             (done_to_op),
        .carry_to_op            (carry_to_op),
        .carry_out_from_au      (carry_out_from_au),
        .reg_b0_from_au         (reg_b0_from_au),
        .reg_c1_from_au         (reg_c1_from_au),
        .reg_c30_from_au        (reg_c30_from_au),
        .do_clear_b_to_au       (do_clear_b_to_au),
        .do_not_b_to_au         (do_not_b_to_au),
        .do_sum_to_au           (do_sum_to_au),
        .do_and_to_au           (do_and_to_au),
        .do_right_shift_bc_to_au(do_right_shift_bc_to_au),
        .do_move_c_to_a_to_au   (do_move_c_to_a_to_au),
        .do_move_c_to_b_to_au   (do_move_c_to_b_to_au),
        .do_move_b_to_c_to_au   (do_move_b_to_c_to_au)
    );

    assign all_outs = {busy_to_op, opnd_req_to_op, done_to_op, carry_to_op,
                       do_clear_b_to_au, do_not_b_to_au, do_sum_to_au, do_and_to_au,
                       do_right_shift_bc_to_au, do_move_c_to_a_to_au,
                       do_move_c_to_b_to_au, do_move_b_to_c_to_au};

    // AU: B[W] is the carry position (B0), C[0] is the multiplier LSB (C30).
    assign au_sum            = {1'b0, au_a} + {1'b0, au_b[W-1:0]} + (W+1)'(au_cin);
    assign carry_out_from_au = au_sum[W];
    assign reg_b0_from_au    = au_b[W];
    assign reg_c1_from_au    = au_c[W-1];
    assign reg_c30_from_au   = au_c[0];

    always @(posedge clk) begin
        if (tb_load_c)               au_c <= tb_load_val;
        if (mem_wr)                  au_c <= opnd_val;
        if (do_clear_b_to_au) begin
            au_b   <= '0;
            au_cin <= 1'b0;
        end
        if (do_move_c_to_a_to_au)    au_a <= au_c;
        if (do_move_c_to_b_to_au)    au_b <= {1'b0, au_c};
        if (do_not_b_to_au) begin
            au_b   <= {1'b0, ~au_b[W-1:0]};
            au_cin <= 1'b1;
        end
        if (do_sum_to_au)            au_b <= au_sum;
        if (do_right_shift_bc_to_au) {au_b, au_c} <= {1'b0, au_b, au_c[W-1:1]};
        if (do_and_to_au)            au_c <= au_a & au_c;
        if (do_move_b_to_c_to_au)    au_c <= au_b[W-1:0];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void ref_op(input logic [1:0] op, input longint unsigned x,
                                   input longint unsigned y,
                                   output longint unsigned c, output logic carry);
        case (op)
            2'd0: begin c = (x + y) % MOD;       carry = (x + y) >= MOD; end
            2'd1: begin c = (x + MOD - y) % MOD; carry = (x >= y);       end
            2'd2: begin c = x & y;               carry = 1'b0;           end
            default: begin c = (x * y) / MOD;    carry = 1'b0;           end
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input int delay);
        case (op)
            2'd0:    return 5 + delay;
            2'd1:    return 6 + delay;
            2'd2:    return 3 + delay;
            default: return 3 + 2 * int'(STEPS) + delay;
        endcase
    endfunction

    // Called at a negedge while idle; returns at the negedge of the cycle after done.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int delay, input int glitch_at,
                          output logic [W-1:0] c, output logic carry, output int lat,
                          output int reqs, output logic busy_after);
        int t0;
        int waited;
        bit seen;
        t0 = int'(cyc);
        start_from_op  = 1'b1;
        op_sel_from_op = op;
        tb_load_c      = 1'b1;
        tb_load_val    = x;
        @(negedge clk);
        tb_load_c = 1'b0;
        waited = 0;
        reqs   = 0;
        seen   = 1'b0;
        lat    = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            start_from_op    = 1'b0;
            opnd_ack_from_op = 1'b0;
            mem_wr           = 1'b0;
            if (int'(cyc) - t0 == glitch_at) begin
                start_from_op    = 1'b1;
                op_sel_from_op   = 2'd0;
                opnd_ack_from_op = 1'b1;
            end
            if (opnd_req_to_op) begin
                reqs++;
                if (waited == delay) begin
                    opnd_ack_from_op = 1'b1;
                    mem_wr           = 1'b1;
                    opnd_val         = y;
                end
                waited++;
            end
            if (done_to_op) begin
                seen = 1'b1;
                lat  = int'(cyc) - t0;
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) check("done within cycle budget", 64'(seen), 64'd1);
        @(negedge clk);
        start_from_op    = 1'b0;
        opnd_ack_from_op = 1'b0;
        mem_wr           = 1'b0;
        c          = au_c;
        carry      = carry_to_op;
        busy_after = busy_to_op;
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           delay;
        logic [W-1:0] exp_c;
        logic         exp_carry;
        int           exp_lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [W-1:0]    c;
        logic            cy;
        logic            b;
        int              lat;
        int              reqs;
        logic [1:0]      rop;
        logic [W-1:0]    rx, ry;
        int              rd;
        longint unsigned ec;
        logic            ecy;

        reset = 1'b1; start_from_op = 1'b0; op_sel_from_op = 2'd0;
        opnd_ack_from_op = 1'b0; tb_load_c = 1'b0; mem_wr = 1'b0;
        tb_load_val = '0; opnd_val = '0;

        vecs[0] = '{2'd0, 30'd5,         30'd7,         0, 30'd12,        1'b0, 5};
        vecs[1] = '{2'd0, 30'h3FFFFFFF,  30'd1,         0, 30'd0,         1'b1, 5};
        vecs[2] = '{2'd1, 30'd10,        30'd3,         0, 30'd7,         1'b1, 6};
        vecs[3] = '{2'd1, 30'd3,         30'd10,        0, 30'h3FFFFFF9,  1'b0, 6};
        vecs[4] = '{2'd2, 30'h2AAAAAAA,  30'h3FFF0000,  0, 30'h2AAA0000,  1'b0, 3};
        vecs[5] = '{2'd2, 30'h2AAAAAAA,  30'h3FFF0000,  4, 30'h2AAA0000,  1'b0, 7};
        vecs[6] = '{2'd3, 30'h20000000,  30'h20000000,  0, 30'h10000000,  1'b0, 63};
        vecs[7] = '{2'd3, 30'h3FFFFFFF,  30'h3FFFFFFF,  0, 30'h3FFFFFFE,  1'b0, 63};
        vecs[8] = '{2'd1, 30'd5,         30'd5,         2, 30'd0,         1'b1, 8};
        vecs[9] = '{2'd0, 30'h1234567,   30'h2000000,   1, 30'h3234567,   1'b0, 6};

        repeat (3) @(negedge clk);
        check("reset outputs", 64'(all_outs), 64'd0);
        reset = 1'b0;

        // Stray ack while idle must not start anything.
        opnd_ack_from_op = 1'b1;
        @(negedge clk);
        opnd_ack_from_op = 1'b0;
        check("stray ack busy", 64'(busy_to_op), 64'd0);
        check("stray ack req", 64'(opnd_req_to_op), 64'd0);

        // Consecutive runs start in the cycle right after done (back-to-back).
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].delay, -1, c, cy, lat, reqs, b);
            check($sformatf("vec%0d C", i), 64'(c), 64'(vecs[i].exp_c));
            check($sformatf("vec%0d carry", i), 64'(cy), 64'(vecs[i].exp_carry));
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d req cycles", i), 64'(reqs), 64'(vecs[i].delay + 1));
            check($sformatf("vec%0d busy after done", i), 64'(b), 64'd0);
        end

        // Start and ack pulsed mid-MUL are ignored.
        run_op(2'd3, 30'h20000000, 30'h20000000, 0, 20, c, cy, lat, reqs, b);
        check("glitch mul C", 64'(c), 64'h10000000);
        check("glitch mul latency", 64'(lat), 64'd63);
        check("glitch mul busy after", 64'(b), 64'd0);

        // Reset at MUL step 12 with carry_to_op previously set.
        run_op(2'd0, 30'h3FFFFFFF, 30'd1, 0, -1, c, cy, lat, reqs, b);
        check("pre-reset carry", 64'(cy), 64'd1);
        start_from_op = 1'b1; op_sel_from_op = 2'd3;
        tb_load_c = 1'b1; tb_load_val = 30'h3FFFFFFF;
        @(negedge clk);
        start_from_op = 1'b0; tb_load_c = 1'b0;
        @(negedge clk);
        check("mid-mul req", 64'(opnd_req_to_op), 64'd1);
        opnd_ack_from_op = 1'b1; mem_wr = 1'b1; opnd_val = 30'h3FFFFFFF;
        @(negedge clk);
        opnd_ack_from_op = 1'b0; mem_wr = 1'b0;
        repeat (24) @(negedge clk);
        check("busy at mul step 12", 64'(busy_to_op), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("outputs after mid-mul reset", 64'(all_outs), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("idle after reset %0d", k), 64'(all_outs), 64'd0);
        end
        run_op(2'd0, 30'd100, 30'd23, 0, -1, c, cy, lat, reqs, b);
        check("post-reset add C", 64'(c), 64'd123);
        check("post-reset add carry", 64'(cy), 64'd0);
        check("post-reset add latency", 64'(lat), 64'd5);

        for (int n = 0; n < 30; n++) begin
            rop = 2'($urandom_range(0, 3));
            rx  = W'($urandom);
            ry  = W'($urandom);
            rd  = int'($urandom_range(0, 3));
            ref_op(rop, longint'(rx), longint'(ry), ec, ecy);
            run_op(rop, rx, ry, rd, -1, c, cy, lat, reqs, b);
            check($sformatf("rand%0d op%0d C", n, rop), 64'(c), 64'(ec));
            check($sformatf("rand%0d op%0d carry", n, rop), 64'(cy), 64'(ecy));
            check($sformatf("rand%0d op%0d latency", n, rop), 64'(lat), 64'(ref_latency(rop, rd)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/arith_ctrl.md
# arith_ctrl

Micro-operation sequencer driving the arithmetic unit (AU) strobes for ADD, SUB, AND and fractional MUL on 30-bit words. Sits between the instruction/operation controller and the AU.
- Issues `do_*_to_au` strobes.
- Samples the AU status bits.
- Requests the second operand from the memory path through a req/ack handshake.

Operand 1 is in AU register C at start. The result is left in C at completion.

## Interface
Parameters:
- `WORD_W`, 30: AU word width.
- `MUL_STEPS`, 30: shift-add iterations for MUL.

Ports (reset is synchronous and active-high; one clock):
- `clk` in 1: clock.
- `reset` in 1: synchronous active-high reset.
- `start_from_op` in 1: one-cycle request; accepted only in IDLE.
- `op_sel_from_op` in 2: operation select, sampled with start: 00 ADD, 01 SUB, 10 AND, 11 MUL.
- `busy_to_op` out 1: high whenever state ≠ IDLE.
- `opnd_req_to_op` out 1: level; asks for operand 2 to be written into C.
- `opnd_ack_from_op` in 1: pulse; C holds operand 2 from the next cycle.
- `done_to_op` out 1: one-cycle pulse; result is in C from the next cycle.
- `carry_to_op` out 1: registered carry/no-borrow flag of the last completed op.
- `carry_out_from_au`, `reg_b0_from_au`, `reg_c1_from_au`, `reg_c30_from_au` in 1 each: AU status.
- `do_clear_b_to_au`, `do_not_b_to_au`, `do_sum_to_au`, `do_and_to_au`, `do_right_shift_bc_to_au`, `do_move_c_to_a_to_au`, `do_move_c_to_b_to_au`, `do_move_b_to_c_to_au` out 1 each: AU strobes.
- Remaining AU strobes are not driven by this block and are tied low at integration.

## Operation
- States: IDLE, LOAD, WAIT_OP, MOVE_B, NEGATE, SUM, STORE, AND_OP, MUL_ADD, MUL_SHIFT.
- Strobes are decoded from the registered state. The only exception is MUL_ADD, whose `do_sum` is gated by `reg_c30_from_au`.
- Op is latched on start.

Common prefix:
- IDLE + start → LOAD.
- LOAD: `do_move_c_to_a` + `do_clear_b` (A←X, B←0, AU carry-in←0). Next state WAIT_OP.
- WAIT_OP: `opnd_req_to_op`=1; stay until `opnd_ack_from_op`.
  - On ack, ADD/SUB → MOVE_B, AND → AND_OP, MUL → MUL_ADD with step counter cleared.

ADD/SUB:
- MOVE_B: `do_move_c_to_b` (B←{0,Y}).
- NEGATE (SUB only): `do_not_b`; sets AU carry-in=1, so the sum forms X−Y.
- SUM: `do_sum`.
- STORE: `do_move_b_to_c`, `done`, `carry_to_op`←`reg_b0_from_au`. For SUB, 1 = no borrow.

AND:
- AND_OP: `do_and` (C←A&C), `done`, `carry_to_op`←0.

MUL (unsigned fraction, C ← floor(X·Y/2^30)):
- MUL_ADD: `do_sum` iff C30=1.
- MUL_SHIFT: `do_right_shift_bc`, counter+1. If counter reaches MUL_STEPS → STORE, else → MUL_ADD.
- STORE as above. `carry_to_op`←B0, which is always 0 for MUL.
- Counter is 5 bits and never wraps: it saturates into STORE at 30.

After STORE or AND_OP → IDLE.

## Timing
- Reset values: all strobes 0, `busy`/`opnd_req`/`done`/`carry_to_op` 0, state IDLE, counter 0.
- Latency, start at cycle T, ack in cycle T+2 (first WAIT_OP cycle), done cycle:
  - ADD: T+5
  - SUB: T+6
  - AND: T+3
  - MUL: T+63
- Each extra ack-wait cycle adds one cycle.
- `start_from_op` while busy: ignored, no effect on op or state.
- `opnd_ack_from_op` outside WAIT_OP: ignored.
- `busy` deasserts the cycle after `done`. A start in that cycle is accepted (back-to-back).
- Reset in any state, including mid-MUL or during WAIT_OP: next cycle IDLE, all outputs 0, no `done`, `carry_to_op` cleared. AU contents are the caller's concern.
- At most one strobe per AU register per cycle. The block never issues conflicting strobes.

## Structure
- Shared package `arith_ctrl_pkg`: op-select encodings, state enum, `WORD_W`, `MUL_STEPS`.
- Single module, no sub-module. The step counter and strobe decode are inline.

## Test plan
Bench instantiates the AU with this block; memory stub acks after N cycles.
- ADD X=5, Y=7, ack immediate → C=12, carry 0, `done` at T+5. X=0x3FFFFFFF, Y=1 → C=0, carry 1.
- SUB 10−3 → C=7, carry 1. SUB 3−10 → C=0x3FFFFFF9, carry 0, `done` at T+6.
- AND 0x2AAAAAAA & 0x3FFF0000 → C=0x2AAA0000, `done` at T+3. Ack delayed 4 cycles → `done` at T+7, `opnd_req` high for exactly 5 cycles.
- MUL 0x20000000×0x20000000 → C=0x10000000. MUL 0x3FFFFFFF×0x3FFFFFFF → C=0x3FFFFFFE, `done` at T+63.
- Start pulsed during a MUL and stray ack in IDLE → no effect. Back-to-back start in the cycle after `done` → accepted.
- Reset asserted at MUL step 12 → next cycle IDLE, all outputs 0. A new ADD then completes correctly.
